// File: rtl/usb3_rx_framer_pkg.sv
// Shared constants and types for the USB3 link-layer RX framer: K-symbol codes,
// ordered-set words, output type encodings and FSM states.
package usb3_rx_framer_pkg;

  localparam logic [7:0] SYM_SHP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_SLC = 8'hFE;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'h7C;
  localparam logic [7:0] SYM_EPF = 8'hF7;

  localparam logic [31:0] HPSTART  = {SYM_SHP, SYM_SHP, SYM_SHP, SYM_EPF};
  localparam logic [31:0] LCSTART  = {SYM_SLC, SYM_SLC, SYM_SLC, SYM_EPF};
  localparam logic [31:0] DPPSTART = {SYM_SDP, SYM_SDP, SYM_SDP, SYM_EPF};

  localparam logic [15:0] CRC16_POLY = 16'h100B;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    TypeHdr  = 2'd0,
    TypeLcmd = 2'd1,
    TypeDpp  = 2'd2
  } out_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLcmd,
    StDpp,
    StDppTail
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  be;
    out_type_e   typ;
    logic        first;
    logic        last;
    logic        abort;
  } out_word_t;

  // Expand a per-byte flag vector into a 32-bit data mask, MSB byte first.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/usb3_rx_framer_if.sv
// Symbol-stream input and tagged payload output of the RX framer.
// slave: the framer itself; master: the surrounding link layer / environment.
interface usb3_rx_framer_if;

  logic        in_active;
  logic [31:0] in_data;
  logic [3:0]  in_datak;

  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [1:0]  out_type;
  logic        out_first;
  logic        out_last;
  logic        out_abort;
  logic        err_frame;
  logic        crc_err;

  modport slave (
    input  in_active, in_data, in_datak,
    output out_valid, out_data, out_be, out_type, out_first, out_last, out_abort,
    output err_frame, crc_err
  );

  modport master (
    output in_active, in_data, in_datak,
    input  out_valid, out_data, out_be, out_type, out_first, out_last, out_abort,
    input  err_frame, crc_err
  );

endinterface

// File: rtl/usb3_crc16.sv
// One 32-bit parallel step of the header CRC-16 (poly 0x100B), bits taken
// MSB first starting with the earliest-received byte.
module usb3_crc16
  import usb3_rx_framer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb3_rx_framer.sv
// USB3 link-layer RX framer: strips HP/LC/DPP framing and emits tagged payload words.
// Header CRC-16 check is built only when USB3_RX_FRAMER_CRC_EN is defined.
module usb3_rx_framer
  import usb3_rx_framer_pkg::*;
#(
  parameter int unsigned HDR_WORDS     = 4,
  parameter int unsigned MAX_DPP_WORDS = 260
) (
  input logic             local_clk,
  input logic             reset_n,
  usb3_rx_framer_if.slave bus
);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] tail_n_q, tail_n_d;
  logic [7:0] tail_sym_q, tail_sym_d;
  out_word_t  word_q, word_d;
  logic       err_q, err_d;
  logic       crc_err_q, crc_err_d;
  logic       crc_bad;

  logic any_k, is_hpstart, is_lcstart, is_dpstart;

  assign any_k      = |bus.in_datak;
  assign is_hpstart = (bus.in_datak == 4'hF) && (bus.in_data == HPSTART);
  assign is_lcstart = (bus.in_datak == 4'hF) && (bus.in_data == LCSTART);
  assign is_dpstart = (bus.in_datak == 4'hF) && (bus.in_data == DPPSTART);

  // DPP terminator decode: lead_n data bytes followed by END/EDB framing.
  logic [1:0]  lead_n;
  logic [3:0]  term_k;
  logic [31:0] k_mask;
  logic [7:0]  term_sym;
  logic        sym_legal, term_full, term_part, term_ok;

  always_comb begin
    if (bus.in_datak[3]) begin
      lead_n = 2'd0;
    end else if (bus.in_datak[2]) begin
      lead_n = 2'd1;
    end else if (bus.in_datak[1]) begin
      lead_n = 2'd2;
    end else begin
      lead_n = 2'd3;
    end
    unique case (lead_n)
      2'd0:    term_sym = bus.in_data[31:24];
      2'd1:    term_sym = bus.in_data[23:16];
      2'd2:    term_sym = bus.in_data[15:8];
      default: term_sym = bus.in_data[7:0];
    endcase
  end

  assign term_k    = 4'b1111 >> lead_n;
  assign k_mask    = byte_mask(term_k);
  assign sym_legal = (term_sym == SYM_END) || (term_sym == SYM_EDB);
  assign term_full = (bus.in_datak == 4'hF) &&
                     (bus.in_data == {term_sym, term_sym, term_sym, SYM_EPF});
  assign term_part = (bus.in_datak == term_k) &&
                     ((bus.in_data & k_mask) == ({4{term_sym}} & k_mask));
  assign term_ok   = sym_legal && ((lead_n == 2'd0) ? term_full : term_part);

  // Remainder of a split terminator: (n-1) end symbols then EPF at word start.
  logic [31:0] tail_exp;
  logic [3:0]  tail_k;
  logic        tail_ok;

  always_comb begin
    unique case (tail_n_q)
      2'd1: begin
        tail_exp = {SYM_EPF, 24'h0};
        tail_k   = 4'b1000;
      end
      2'd2: begin
        tail_exp = {tail_sym_q, SYM_EPF, 16'h0};
        tail_k   = 4'b1100;
      end
      2'd3: begin
        tail_exp = {tail_sym_q, tail_sym_q, SYM_EPF, 8'h0};
        tail_k   = 4'b1110;
      end
      default: begin
        tail_exp = '0;
        tail_k   = 4'b0000;
      end
    endcase
  end

  assign tail_ok = ((bus.in_datak & tail_k) == tail_k) &&
                   ((bus.in_data & byte_mask(tail_k)) == tail_exp);

`ifdef USB3_RX_FRAMER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_step;

  usb3_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data    (bus.in_data),
    .crc_out (crc_step)
  );

  always_comb begin
    crc_d = crc_q;
    if (state_q == StIdle && bus.in_active && is_hpstart) begin
      crc_d = CRC16_INIT;
    end else if (state_q == StHdr && bus.in_active && !any_k &&
                 cnt_q < 9'(HDR_WORDS - 1)) begin
      crc_d = crc_step;
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_bad = (bus.in_data[31:16] != ~crc_q);
`else
  assign crc_bad = 1'b0;
`endif

  out_type_e cur_type;
  logic      drop;

  assign cur_type = (state_q == StHdr) ? TypeHdr : TypeDpp;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tail_n_d   = tail_n_q;
    tail_sym_d = tail_sym_q;
    word_d     = '0;
    err_d      = 1'b0;
    crc_err_d  = 1'b0;
    drop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_active && any_k) begin
          if (is_hpstart) begin
            state_d = StHdr;
            cnt_d   = '0;
          end else if (is_lcstart) begin
            state_d = StLcmd;
          end else if (is_dpstart) begin
            state_d = StDpp;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StHdr: begin
        if (!bus.in_active || any_k) begin
          drop = 1'b1;
        end else begin
          word_d.valid = 1'b1;
          word_d.data  = bus.in_data;
          word_d.be    = 4'hF;
          word_d.typ   = TypeHdr;
          word_d.first = (cnt_q == '0);
          cnt_d        = cnt_q + 9'd1;
          if (cnt_q == 9'(HDR_WORDS - 1)) begin
            word_d.last  = 1'b1;
            word_d.abort = crc_bad;
            crc_err_d    = crc_bad;
            state_d      = StIdle;
          end
        end
      end

      StLcmd: begin
        if (bus.in_active) begin
          word_d.valid = 1'b1;
          word_d.data  = bus.in_data;
          word_d.be    = 4'hF;
          word_d.typ   = TypeLcmd;
          word_d.first = 1'b1;
          word_d.last  = 1'b1;
          state_d      = StIdle;
        end
      end

      StDpp: begin
        if (!bus.in_active) begin
          drop = 1'b1;
        end else if (!any_k) begin
          if (cnt_q == 9'(MAX_DPP_WORDS)) begin
            drop = 1'b1;
          end else begin
            word_d.valid = 1'b1;
            word_d.data  = bus.in_data;
            word_d.be    = 4'hF;
            word_d.typ   = TypeDpp;
            word_d.first = (cnt_q == '0);
            cnt_d        = cnt_q + 9'd1;
          end
        end else if (!term_ok) begin
          drop = 1'b1;
        end else begin
          word_d.valid = 1'b1;
          word_d.data  = bus.in_data & ~k_mask;
          word_d.be    = ~term_k;
          word_d.typ   = TypeDpp;
          word_d.first = (cnt_q == '0);
          word_d.last  = 1'b1;
          word_d.abort = (term_sym == SYM_EDB);
          tail_n_d     = lead_n;
          tail_sym_d   = term_sym;
          state_d      = (lead_n == 2'd0) ? StIdle : StDppTail;
        end
      end

      StDppTail: begin
        if (!bus.in_active) begin
          drop = 1'b1;
        end else begin
          err_d   = !tail_ok;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Truncated or malformed packet: close it with an empty aborted last word.
    if (drop) begin
      word_d       = '0;
      word_d.valid = 1'b1;
      word_d.typ   = cur_type;
      word_d.last  = 1'b1;
      word_d.abort = 1'b1;
      err_d        = 1'b1;
      state_d      = StIdle;
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tail_n_q   <= '0;
      tail_sym_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tail_n_q   <= tail_n_d;
      tail_sym_q <= tail_sym_d;
      word_q     <= word_d;
      err_q      <= err_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign bus.out_valid = word_q.valid;
  assign bus.out_data  = word_q.data;
  assign bus.out_be    = word_q.be;
  assign bus.out_type  = word_q.typ;
  assign bus.out_first = word_q.first;
  assign bus.out_last  = word_q.last;
  assign bus.out_abort = word_q.abort;
  assign bus.err_frame = err_q;
  assign bus.crc_err   = crc_err_q;

endmodule

// File: tb/tb_usb3_rx_framer.sv
// Directed self-checking bench for usb3_rx_framer; covers the CRC-16 check too
// when USB3_RX_FRAMER_CRC_EN is defined.
module tb_usb3_rx_framer;

`ifdef USB3_RX_FRAMER_CRC_EN
  localparam bit CrcOn = 1'b1;
`else
  localparam bit CrcOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  usb3_rx_framer_if bus ();

  usb3_rx_framer dut (
    .local_clk (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control fields packed as {valid, be, type, first, last, abort, err_frame, crc_err}.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic [3:0] be, input logic [1:0] t, input logic f,
                            input logic l, input logic a, input logic e, input logic c);
    check({tag, ".ctl"},
          {20'h0, bus.out_valid, bus.out_be, bus.out_type, bus.out_first, bus.out_last,
           bus.out_abort, bus.err_frame, bus.crc_err},
          {20'h0, v, be, t, f, l, a, e, c});
    check({tag, ".data"}, bus.out_data, d);
  endtask

  task automatic expect_none(input string tag, input logic e);
    expect_out(tag, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, e, 1'b0);
  endtask

  task automatic step(input logic act, input logic [31:0] d, input logic [3:0] k);
    @(negedge clk);
    bus.in_active = act;
    bus.in_data   = d;
    bus.in_datak  = k;
    @(posedge clk);
    #1;
  endtask

  // Reference CRC-16 over 12 header bytes, bytes in arrival order, bits MSB first.
  function automatic logic [15:0] crc16_ref(input logic [95:0] hdr);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int n = 0; n < 12; n++) begin
      b = hdr[95 - 8*n -: 8];
      for (int i = 7; i >= 0; i--) begin
        if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
        else              c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [31:0] h0, h1, h2, h3;

  initial begin
    h0 = 32'h01020304;
    h1 = 32'h05060708;
    h2 = 32'h090A0B0C;
    h3 = {~crc16_ref({h0, h1, h2}), 16'h5A5A};

    bus.in_active = 1'b0;
    bus.in_data   = '0;
    bus.in_datak  = '0;

    // Reset holds outputs at zero even with a start set on the input.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    expect_none("rst0", 1'b0);
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    expect_none("rst1", 1'b0);
    reset_n = 1'b1;

    // Header packet.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    expect_none("hp.start", 1'b0);
    step(1'b1, h0, 4'h0);
    expect_out("hp.w0", 1, h0, 4'hF, 2'd0, 1, 0, 0, 0, 0);
    step(1'b1, h1, 4'h0);
    expect_out("hp.w1", 1, h1, 4'hF, 2'd0, 0, 0, 0, 0, 0);
    step(1'b1, h2, 4'h0);
    expect_out("hp.w2", 1, h2, 4'hF, 2'd0, 0, 0, 0, 0, 0);
    step(1'b1, h3, 4'h0);
    expect_out("hp.w3", 1, h3, 4'hF, 2'd0, 0, 1, 0, 0, 0);

    // Logical idle dropped silently; an unknown K word flags an error.
    step(1'b1, 32'hDEADBEEF, 4'h0);
    expect_none("idle.data", 1'b0);
    step(1'b1, 32'h000000BC, 4'h1);
    expect_none("idle.kerr", 1'b1);

    // Link command, with an inactive cycle in between that must be ignored.
    step(1'b1, 32'hFEFEFEF7, 4'hF);
    expect_none("lc.start", 1'b0);
    step(1'b0, 32'hFFFFFFFF, 4'hF);
    expect_none("lc.gap", 1'b0);
    step(1'b1, 32'h12345678, 4'h0);
    expect_out("lc.w0", 1, 32'h12345678, 4'hF, 2'd1, 1, 1, 0, 0, 0);

    // Data packet ending with one data byte, END framing split across words.
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    expect_none("dp.start", 1'b0);
    step(1'b1, 32'hAABBCCDD, 4'h0);
    expect_out("dp.w0", 1, 32'hAABBCCDD, 4'hF, 2'd2, 1, 0, 0, 0, 0);
    step(1'b1, 32'h11223344, 4'h0);
    expect_out("dp.w1", 1, 32'h11223344, 4'hF, 2'd2, 0, 0, 0, 0, 0);
    step(1'b1, 32'h55FDFDFD, 4'h7);
    expect_out("dp.end", 1, 32'h55000000, 4'h8, 2'd2, 0, 1, 0, 0, 0);
    step(1'b1, 32'hF7AABBCC, 4'h8);
    expect_none("dp.tail", 1'b0);

    // Same packet nullified by a full EDB set.
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    step(1'b1, 32'hAABBCCDD, 4'h0);
    expect_out("edb.w0", 1, 32'hAABBCCDD, 4'hF, 2'd2, 1, 0, 0, 0, 0);
    step(1'b1, 32'h11223344, 4'h0);
    step(1'b1, 32'h7C7C7CF7, 4'hF);
    expect_out("edb.end", 1, 32'h0, 4'h0, 2'd2, 0, 1, 1, 0, 0);

    // Two-byte tail with END: good tail, then a three-byte tail that is wrong.
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    step(1'b1, 32'hA1B2FDFD, 4'h3);
    expect_out("t2.end", 1, 32'hA1B20000, 4'hC, 2'd2, 1, 1, 0, 0, 0);
    step(1'b1, 32'hFDF71234, 4'hC);
    expect_none("t2.tail", 1'b0);
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    step(1'b1, 32'h112233FD, 4'h1);
    expect_out("t3.end", 1, 32'h11223300, 4'hE, 2'd2, 1, 1, 0, 0, 0);
    step(1'b1, 32'hFD7CF700, 4'hE);
    expect_none("t3.badtail", 1'b1);

    // Empty payload closed by END: zero-be last word, no abort.
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    step(1'b1, 32'hFDFDFDF7, 4'hF);
    expect_out("empty.end", 1, 32'h0, 4'h0, 2'd2, 1, 1, 0, 0, 0);

    // in_active drops after two header words, then a fresh header is accepted.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    step(1'b1, h0, 4'h0);
    step(1'b1, h1, 4'h0);
    expect_out("drop.w1", 1, h1, 4'hF, 2'd0, 0, 0, 0, 0, 0);
    step(1'b0, 32'h0, 4'h0);
    expect_out("drop.abort", 1, 32'h0, 4'h0, 2'd0, 0, 1, 1, 1, 0);
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    expect_none("drop.restart", 1'b0);
    step(1'b1, h0, 4'h0);
    expect_out("drop.r0", 1, h0, 4'hF, 2'd0, 1, 0, 0, 0, 0);
    step(1'b1, h1, 4'h0);
    step(1'b1, h2, 4'h0);
    step(1'b1, h3, 4'h0);
    expect_out("drop.r3", 1, h3, 4'hF, 2'd0, 0, 1, 0, 0, 0);

    // Start set inside a header aborts it.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    step(1'b1, h0, 4'h0);
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    expect_out("hp.kbyte", 1, 32'h0, 4'h0, 2'd0, 0, 1, 1, 1, 0);
    step(1'b1, h1, 4'h0);
    expect_none("hp.norestart", 1'b0);

    // Header with byte 13 corrupted: only the CRC build flags it.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    step(1'b1, h0, 4'h0);
    step(1'b1, h1, 4'h0);
    step(1'b1, h2, 4'h0);
    step(1'b1, h3 ^ 32'h00FF0000, 4'h0);
    expect_out("crc.bad", 1, h3 ^ 32'h00FF0000, 4'hF, 2'd0, 0, 1, CrcOn, 0, CrcOn);

    // Payload length limit: MAX_DPP_WORDS words pass, the next one aborts.
    step(1'b1, 32'h5C5C5CF7, 4'hF);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 32'hC0DE0000 + 32'(i), 4'h0);
      expect_out($sformatf("max.w%0d", i), 1, 32'hC0DE0000 + 32'(i), 4'hF, 2'd2,
                 (i == 0), 0, 0, 0, 0);
    end
    step(1'b1, 32'h0BADF00D, 4'h0);
    expect_out("max.over", 1, 32'h0, 4'h0, 2'd2, 0, 1, 1, 1, 0);

    // Reset mid-packet: immediate idle, no abort word, next data word dropped.
    step(1'b1, 32'hFBFBFBF7, 4'hF);
    step(1'b1, h0, 4'h0);
    reset_n = 1'b0;
    step(1'b1, h1, 4'h0);
    expect_none("rst.mid", 1'b0);
    reset_n = 1'b1;
    step(1'b1, h2, 4'h0);
    expect_none("rst.idle", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
